// File: rtl/pio_uart_rx_ctrl.sv
// pio_uart_rx_ctrl: boots a PIO with a relocated UART RX program and a
// config list, then drains the chosen machine's RX FIFO onto valid/ready.
module pio_uart_rx_ctrl #(
  parameter int PROG_LEN = 32,
  parameter int CONF_LEN = 6,
  parameter int OFFSET   = 4,
  parameter int SM       = 0,
  parameter int DATA_LSB = 24,
  // ROM images: entry i at [i*16 +: 16] and [i*36 +: 36]
  parameter logic [511:0] PROG_INIT =
    512'h8020_0000_20a0_c014_00c8_0642_4001_ea27_2020,
  parameter logic [1151:0] CONF_INIT =
    1152'h8_0000_0001_7_0000_0000_6_8000_0000_4_0000_0200_3_0000_0400_2_00d9_0000
) (
  input  logic        clk_25mhz,
  input  logic        reset,
  output logic [31:0] din,
  output logic [4:0]  index,
  output logic [3:0]  action,
  output logic [1:0]  mindex,
  input  logic [31:0] dout,
  input  logic [3:0]  rx_empty,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        cfg_done,
  output logic [15:0] byte_count
);

  typedef enum logic [2:0] {
    S_LOAD, S_CONF, S_IDLE, S_PULL, S_CAP
  } state_t;

  localparam logic [4:0] P_OFF  = 5'(OFFSET);
  localparam logic [4:0] P_LAST = 5'(PROG_LEN - 1);
  localparam logic [5:0] C_LEN  = 6'(CONF_LEN);
  localparam logic [1:0] P_SM   = 2'(SM);
  localparam logic [3:0] A_NONE = 4'd0;
  localparam logic [3:0] A_WR   = 4'd1;
  localparam logic [3:0] A_PULL = 4'd5;

  state_t      r_state, w_state_n;
  logic [4:0]  r_pindex, w_pindex_n;
  logic [5:0]  r_cindex, w_cindex_n;
  logic [31:0] r_din, w_din_n;
  logic [4:0]  r_index, w_index_n;
  logic [3:0]  r_action, w_action_n;
  logic [1:0]  r_mindex, w_mindex_n;
  logic [7:0]  r_rx_data, w_rx_data_n;
  logic        r_rx_valid, w_rx_valid_n;
  logic        r_cfg_done, w_cfg_done_n;
  logic [15:0] r_byte_count, w_byte_count_n;

  logic [15:0] w_instr;
  logic [4:0]  w_tgt;
  logic [15:0] w_reloc;
  logic [35:0] w_conf;
  logic [7:0]  w_byte;
  logic        w_unused;

  assign w_instr = PROG_INIT[{r_pindex, 4'b0000} +: 16];
  assign w_tgt   = w_instr[4:0] + P_OFF;
  // only JMP targets are absolute and need moving with the load address
  assign w_reloc = (w_instr[15:13] == 3'b000) ?
                   {w_instr[15:5], w_tgt} : w_instr;
  assign w_conf  = CONF_INIT[r_cindex[4:0] * 36 +: 36];
  assign w_byte  = dout[DATA_LSB +: 8];
  assign w_unused = ^{dout, rx_empty};

  always_comb begin
    w_state_n      = r_state;
    w_pindex_n     = r_pindex;
    w_cindex_n     = r_cindex;
    w_din_n        = r_din;
    w_index_n      = r_index;
    w_action_n     = A_NONE;
    w_mindex_n     = r_mindex;
    w_rx_data_n    = r_rx_data;
    w_rx_valid_n   = r_rx_valid;
    w_cfg_done_n   = r_cfg_done;
    w_byte_count_n = r_byte_count;
    if (r_rx_valid && rx_ready)
      w_rx_valid_n = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_action_n = A_WR;
        w_index_n  = r_pindex + P_OFF;
        w_din_n    = {16'h0000, w_reloc};
        w_mindex_n = P_SM;
        if (r_pindex == P_LAST)
          w_state_n = S_CONF;
        else
          w_pindex_n = r_pindex + 5'd1;
      end
      S_CONF: begin
        if (r_cindex == C_LEN) begin
          w_cfg_done_n = 1'b1;
          w_state_n    = S_IDLE;
        end else begin
          w_action_n = w_conf[35:32];
          w_din_n    = w_conf[31:0];
          w_cindex_n = r_cindex + 6'd1;
        end
      end
      S_IDLE: begin
        // a held byte blocks the pull; backpressure stays in the PIO FIFO
        if (!rx_empty[P_SM] && !r_rx_valid) begin
          w_action_n = A_PULL;
          w_mindex_n = P_SM;
          w_state_n  = S_PULL;
        end
      end
      S_PULL: w_state_n = S_CAP;
      S_CAP: begin
        w_rx_data_n    = w_byte;
        w_rx_valid_n   = 1'b1;
        w_byte_count_n = r_byte_count + 16'd1;
        w_state_n      = S_IDLE;
      end
      default: w_state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_pindex     <= '0;
      r_cindex     <= '0;
      r_din        <= '0;
      r_index      <= '0;
      r_action     <= A_NONE;
      r_mindex     <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_cfg_done   <= 1'b0;
      r_byte_count <= '0;
    end else begin
      r_state      <= w_state_n;
      r_pindex     <= w_pindex_n;
      r_cindex     <= w_cindex_n;
      r_din        <= w_din_n;
      r_index      <= w_index_n;
      r_action     <= w_action_n;
      r_mindex     <= w_mindex_n;
      r_rx_data    <= w_rx_data_n;
      r_rx_valid   <= w_rx_valid_n;
      r_cfg_done   <= w_cfg_done_n;
      r_byte_count <= w_byte_count_n;
    end
  end

  assign din        = r_din;
  assign index      = r_index;
  assign action     = r_action;
  assign mindex     = r_mindex;
  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign cfg_done   = r_cfg_done;
  assign byte_count = r_byte_count;

endmodule
